lsu: RTL



---
 rtl/lsu.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : RV32I load/store unit. Byte/half/word accesses over a req/ack
//            bus, with sign/zero extension of load data for writeback.
//            Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        err_timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  w_size;
    logic        w_illegal;
    logic        w_misalign;
    logic [1:0]  w_lane;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    // Request decode, evaluated on the inputs while IDLE.
    always_comb begin
        w_size    = funct3_i[1:0];
        w_lane    = 2'b00;
        w_wdata   = wdata_i;
        w_wstrb   = 4'b1111;
        if (is_store_i) begin
            w_illegal = funct3_i[2] | (w_size == 2'b11);
        end else begin
            w_illegal = (w_size == 2'b11) | (funct3_i == 3'b110);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((w_size == 2'b01) & addr_i[0]) |
                     ((w_size == 2'b10) & (addr_i[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        // Without the trap, half/word lanes snap to the natural alignment.
        case (w_size)
            2'b00: begin
                w_lane  = addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
                w_wstrb = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                w_lane  = {addr_i[1], 1'b0};
                w_wdata = {2{wdata_i[15:0]}};
                w_wstrb = 4'b0011 << {addr_i[1], 1'b0};
            end
            default: begin
                w_lane  = 2'b00;
                w_wdata = wdata_i;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!is_store_i) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load extraction from the returned word at the captured lane.
    always_comb begin
        w_shifted = mem_rdata_i >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'b0, w_shifted[7:0]};
            3'b101:  w_load = {16'b0, w_shifted[15:0]};
            default: w_load = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        wstrb_d  = wstrb_q;
        we_d     = we_q;
        lane_d   = lane_q;
        funct3_d = funct3_q;
        tmo_d    = tmo_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    maddr_d  = {addr_i[31:2], 2'b00};
                    mwdata_d = w_wdata;
                    wstrb_d  = w_wstrb;
                    we_d     = is_store_i;
                    lane_d   = w_lane;
                    funct3_d = funct3_i;
                    cnt_d    = 8'd0;
                    tmo_d    = 1'b0;
                    state_d  = (w_illegal | w_misalign) ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the final wait cycle still completes the access.
                if (mem_ack_i) begin
                    if (!we_q) begin
                        rdata_d = w_load;
                    end
                    state_d = S_RESP;
                end else if ((cnt_q + 8'd1) == c_max_wait) begin
                    tmo_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            maddr_q  <= 32'd0;
            mwdata_q <= 32'd0;
            wstrb_q  <= 4'd0;
            we_q     <= 1'b0;
            lane_q   <= 2'd0;
            funct3_q <= 3'd0;
            tmo_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            wstrb_q  <= wstrb_d;
            we_q     <= we_d;
            lane_q   <= lane_d;
            funct3_q <= funct3_d;
            tmo_q    <= tmo_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_RESP);
    assign err_o         = (state_q == S_ERR);
    assign err_timeout_o = err_o & tmo_q;
    assign mem_req_o     = (state_q == S_REQ);
    assign mem_we_o      = mem_req_o & we_q;
    assign mem_addr_o    = maddr_q;
    assign mem_wdata_o   = mwdata_q;
    assign mem_wstrb_o   = mem_req_o ? wstrb_q : 4'b0000;
    assign rdata_o       = rdata_q;

endmodule
`default_nettype wire
